// File: rtl/z80db_pkg.sv
// Shared types and constants for the Z80 shadow-RAM mapper.
package z80db_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARM_ON  = 2'd1,
    ST_ON      = 2'd2,
    ST_ARM_OFF = 2'd3
  } shadow_state_t;

  localparam int LOCK_BIT = 5;
  localparam int WP_BIT   = 6;

  localparam logic [7:0] DEF_PORT_LO  = 8'hFD;
  localparam logic [1:0] DEF_PORT_HI  = 2'b01;
  localparam logic [7:0] DEF_ON_PORT  = 8'hFB;
  localparam logic [7:0] DEF_OFF_PORT = 8'h7B;

endpackage

// File: rtl/z80_strobe_edge.sv
// Two-flop strobe sampler producing a one-clk pulse on each assertion of sig.
module z80_strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic now_smp;
  logic prev_smp;

  // sample history: now_smp is the current sample, prev_smp the one before
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      now_smp  <= 1'b0;
      prev_smp <= 1'b0;
    end else begin
      prev_smp <= now_smp;
      now_smp  <= sig;
    end
  end

  assign pulse = now_smp && !prev_smp;

endmodule

// File: rtl/z80_shadow_mapper.sv
// Shadow-RAM controller: maps low 16 KB windows onto banked SRAM, traps
// I/O reads to switch the shadow map in on the following opcode fetch.
module z80_shadow_mapper
  import z80db_pkg::*;
#(
  parameter int         BANK_BITS  = 2,
  parameter int         CACHE_WIN  = 1,
  parameter logic [7:0] PORT_LO    = DEF_PORT_LO,
  parameter logic [1:0] PORT_HI    = DEF_PORT_HI,
  parameter logic [7:0] ON_PORT    = DEF_ON_PORT,
  parameter logic [7:0] OFF_PORT   = DEF_OFF_PORT,
  parameter int         BANK_LSB   = 4,
  parameter bit         BOOT_CACHE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bsrq,
  input  logic                 mreq_n,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 m1_n,
  input  logic [7:0]           a_lo,
  input  logic [1:0]           a_hi,
  input  logic [7:0]           d_in,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ce_n,
  output logic [BANK_BITS-1:0] sram_ba,
  output logic                 romblk
);

  localparam shadow_state_t RST_STATE = BOOT_CACHE ? ST_ON : ST_OFF;
  localparam logic [1:0]    WIN_LIM   = 2'(CACHE_WIN);

  shadow_state_t state;
  shadow_state_t next_state;
  logic [7:0]    ctl;

  logic win_hit, reg_hit, iord, iowr, fetch;
  logic iord_p, iowr_p, fetch_p;
  logic on_trap, off_trap, act, sel;

  assign win_hit  = (a_hi < WIN_LIM);
  assign reg_hit  = (a_lo == PORT_LO) && (a_hi == PORT_HI);
  assign iord     = !iorq_n && !rd_n;
  assign iowr     = !iorq_n && !wr_n;
  assign fetch    = !m1_n && !mreq_n;
  assign on_trap  = iord_p && (a_lo == ON_PORT);
  assign off_trap = iord_p && (a_lo == OFF_PORT);

  z80_strobe_edge u_iord  (.clk(clk), .reset(reset), .sig(iord),  .pulse(iord_p));
  z80_strobe_edge u_iowr  (.clk(clk), .reset(reset), .sig(iowr),  .pulse(iowr_p));
  z80_strobe_edge u_fetch (.clk(clk), .reset(reset), .sig(fetch), .pulse(fetch_p));

  // control register, frozen once LOCK is set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl <= 8'h00;
    end else if (iowr_p && reg_hit && !ctl[LOCK_BIT]) begin
      ctl <= d_in;
    end
  end

  // shadow state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST_STATE;
    end else begin
      state <= next_state;
    end
  end

  // shadow next-state: arm on a trap read, commit on the next M1 fetch
  always_comb begin
    next_state = state;
    case (state)
      ST_OFF: begin
        if (on_trap) next_state = ST_ARM_ON;
        else         next_state = ST_OFF;
      end
      ST_ARM_ON: begin
        if (fetch_p)       next_state = ST_ON;
        else if (off_trap) next_state = ST_OFF;
        else               next_state = ST_ARM_ON;
      end
      ST_ON: begin
        if (off_trap) next_state = ST_ARM_OFF;
        else          next_state = ST_ON;
      end
      ST_ARM_OFF: begin
        if (fetch_p)      next_state = ST_OFF;
        else if (on_trap) next_state = ST_ON;
        else              next_state = ST_ARM_OFF;
      end
      default: next_state = RST_STATE;
    endcase
  end

  assign act       = (state == ST_ON) || (state == ST_ARM_OFF);
  assign sel       = !bsrq || act;
  assign sram_ce_n = !(sel && win_hit && !mreq_n);
  assign sram_oe_n = sram_ce_n || rd_n;
  // write-protect only gates CPU writes, never the external master
  assign sram_we_n = sram_ce_n || wr_n || (act && bsrq && ctl[WP_BIT]);
  assign sram_ba   = ctl[BANK_LSB +: BANK_BITS];
  assign romblk    = act || !bsrq;
  assign d_oe      = iord && reg_hit;
  assign d_out     = ctl;

endmodule

// File: tb/tb_z80_shadow_mapper.sv
// Directed bench for z80_shadow_mapper: one-window and two-window instances share stimulus.
module tb_z80_shadow_mapper;
  import z80db_pkg::*;

  logic clk = 1'b0;
  logic reset, bsrq, mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic [7:0] a_lo, d_in;
  logic [1:0] a_hi;

  logic [7:0] d_out, d_out2;
  logic       d_oe, d_oe2, oe_n, oe_n2, we_n, we_n2, ce_n, ce_n2, romblk, romblk2;
  logic [1:0] ba, ba2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  z80_shadow_mapper u_dut (
    .clk(clk), .reset(reset), .bsrq(bsrq), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .a_lo(a_lo), .a_hi(a_hi), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_ce_n(ce_n), .sram_ba(ba), .romblk(romblk)
  );

  z80_shadow_mapper #(.CACHE_WIN(2)) u_win2 (
    .clk(clk), .reset(reset), .bsrq(bsrq), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .a_lo(a_lo), .a_hi(a_hi), .d_in(d_in),
    .d_out(d_out2), .d_oe(d_oe2), .sram_oe_n(oe_n2), .sram_we_n(we_n2),
    .sram_ce_n(ce_n2), .sram_ba(ba2), .romblk(romblk2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic io_start(input logic is_rd, input logic [1:0] hi, input logic [7:0] lo,
                          input logic [7:0] d);
    a_hi = hi; a_lo = lo; d_in = d; iorq_n = 1'b0;
    rd_n = !is_rd; wr_n = is_rd;
  endtask

  task automatic io_end();
    tick(); tick();
    bus_idle();
    tick();
  endtask

  task automatic m1_fetch();
    a_hi = 2'b00; a_lo = 8'h00; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    io_end();
  endtask

  initial begin
    reset = 1'b0; bsrq = 1'b1; a_lo = 8'h00; a_hi = 2'b00; d_in = 8'h00;
    bus_idle();
    tick(); tick();
    reset = 1'b1;
    tick();

    // reset state with a plain ROM read of 0x0000
    mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("rst_ce_n",   {7'd0, ce_n}, 8'h01);
    check("rst_romblk", {7'd0, romblk}, 8'h00);
    check("rst_ba",     {6'd0, ba}, 8'h00);
    check("rst_state",  {6'd0, u_dut.state}, {6'd0, ST_OFF});
    check("rst_ctl",    d_out, 8'h00);
    bus_idle(); tick();

    // IN 0xFB arms, following M1 commits
    io_start(1'b1, 2'b00, 8'hFB, 8'h00);
    tick();
    check("in_fb_romblk_a", {7'd0, romblk}, 8'h00);
    tick();
    check("in_fb_romblk_b", {7'd0, romblk}, 8'h00);
    check("arm_on_state", {6'd0, u_dut.state}, {6'd0, ST_ARM_ON});
    bus_idle(); tick();
    a_hi = 2'b00; a_lo = 8'h00; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check("fetch_pulse_romblk", {7'd0, romblk}, 8'h00);
    tick();
    check("on_romblk", {7'd0, romblk}, 8'h01);
    check("on_ce_n",   {7'd0, ce_n}, 8'h00);
    check("on_oe_n",   {7'd0, oe_n}, 8'h00);
    bus_idle(); tick();

    // WP set: CPU write blocked, external master write passes
    io_start(1'b0, 2'b01, 8'hFD, 8'h40);
    io_end();
    check("wp_ctl", d_out, 8'h40);
    a_hi = 2'b00; a_lo = 8'h34; mreq_n = 1'b0; wr_n = 1'b0;
    #1;
    check("wp_ce_n", {7'd0, ce_n}, 8'h00);
    check("wp_we_n", {7'd0, we_n}, 8'h01);
    bsrq = 1'b0;
    #1;
    check("ext_we_n", {7'd0, we_n}, 8'h00);
    bsrq = 1'b1;
    bus_idle(); tick();

    // OUT 0x30 locks, OUT 0x10 ignored, IN readback
    io_start(1'b0, 2'b01, 8'hFD, 8'h30);
    io_end();
    check("lock_ctl", d_out, 8'h30);
    check("lock_ba",  {6'd0, ba}, 8'h03);
    io_start(1'b0, 2'b01, 8'hFD, 8'h10);
    io_end();
    check("locked_ctl", d_out, 8'h30);
    io_start(1'b1, 2'b01, 8'hFD, 8'h00);
    #1;
    check("rb_d_oe",  {7'd0, d_oe}, 8'h01);
    check("rb_d_out", d_out, 8'h30);
    io_end();
    check("rb_idle_d_oe", {7'd0, d_oe}, 8'h00);

    // window size: 0x4000 and 0x8000
    a_hi = 2'b01; a_lo = 8'h00; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("w1_4000_ce_n", {7'd0, ce_n}, 8'h01);
    check("w2_4000_ce_n", {7'd0, ce_n2}, 8'h00);
    a_hi = 2'b10;
    #1;
    check("w2_8000_ce_n", {7'd0, ce_n2}, 8'h01);
    bus_idle(); tick();

    // IN 0x7B arms off; shadow stays active until M1
    io_start(1'b1, 2'b00, 8'h7B, 8'h00);
    io_end();
    check("arm_off_romblk", {7'd0, romblk}, 8'h01);
    m1_fetch();
    check("off_romblk", {7'd0, romblk}, 8'h00);
    check("off_state", {6'd0, u_dut.state}, {6'd0, ST_OFF});

    // IN 0xFB then IN 0x7B without M1 cancels the arm
    io_start(1'b1, 2'b00, 8'hFB, 8'h00);
    io_end();
    check("cancel_romblk_a", {7'd0, romblk}, 8'h00);
    io_start(1'b1, 2'b00, 8'h7B, 8'h00);
    io_end();
    check("cancel_romblk_b", {7'd0, romblk}, 8'h00);
    check("cancel_state", {6'd0, u_dut.state}, {6'd0, ST_OFF});

    // back on, then reset during an access
    io_start(1'b1, 2'b00, 8'hFB, 8'h00);
    io_end();
    m1_fetch();
    check("reon_romblk2", {7'd0, romblk2}, 8'h01);
    a_hi = 2'b01; a_lo = 8'h00; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("reon_w2_ce_n", {7'd0, ce_n2}, 8'h00);
    reset = 1'b0;
    #1;
    check("midrst_romblk",  {7'd0, romblk}, 8'h00);
    check("midrst_romblk2", {7'd0, romblk2}, 8'h00);
    check("midrst_w2_ce_n", {7'd0, ce_n2}, 8'h01);
    check("midrst_ctl",     d_out, 8'h00);
    bus_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
